// File: rtl/mod3_serial_tx_if.sv
// mod3_serial_tx_if: parallel-word handshake in, serial frame with mod-3 residue out.
interface mod3_serial_tx_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_last;
    logic [1:0]       residue;
    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, frame_start, frame_last, residue
    );
    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, frame_start, frame_last, residue
    );
endinterface

// File: rtl/mod3_serial_tx.sv
// mod3_serial_tx: shifts a word out MSB-first, then its 2-bit residue (word mod 3).
module mod3_serial_tx #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    mod3_serial_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, DATA, RES} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0] cnt;
    logic [1:0] r, r_nx;
    logic [2:0] v;
    logic ridx, accept;
    // 2r+b is at most 5, so a single conditional subtract keeps r in 0..2
    assign v = {r, shift[WIDTH-1]};
    assign r_nx = (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    assign accept = bus.din_valid && bus.din_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        bus.sout = 1'b0;
        bus.sout_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_last = 1'b0;
        bus.din_ready = !rst && (state == IDLE || (state == RES && ridx));
        case (state)
            IDLE: state_n = accept ? DATA : IDLE;
            DATA: begin
                bus.sout = shift[WIDTH-1];
                bus.sout_valid = 1'b1;
                bus.frame_start = (cnt == '0);
                state_n = (cnt == LAST) ? RES : DATA;
            end
            RES: begin
                bus.sout = ridx ? r[0] : r[1];
                bus.sout_valid = 1'b1;
                bus.frame_last = ridx;
                state_n = ridx ? (bus.din_valid ? DATA : IDLE) : RES;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
            cnt <= '0;
            r <= '0;
            ridx <= 1'b0;
            bus.residue <= '0;
        end else begin
            if (accept) begin
                shift <= bus.din;
                cnt <= '0;
                r <= '0;
            end else if (state == DATA) begin
                shift <= shift << 1;
                cnt <= cnt + 1'b1;
                r <= r_nx;
            end
            ridx <= (state == RES) ? ~ridx : 1'b0;
            if (state == RES && ridx) bus.residue <= r;
        end
    end
endmodule

// File: tb/tb_mod3_serial_tx.sv
// tb_mod3_serial_tx: vector table, hand-written corner sequences and a random run against a word-mod-3 model.
module tb_mod3_serial_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    mod3_serial_tx_if #(.WIDTH(8)) bus();
    mod3_serial_tx #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] d;
        logic [9:0] bits;
        logic [1:0] res;
    } vec_t;
    vec_t tbl[6];
    logic [7:0] exp_q[$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    // Checks one 10-cycle frame; at i==0 drives the next word, at i==inj injects a word mid-frame.
    task automatic frame_check(input string nm, input logic [9:0] bits, input logic [7:0] next_d,
                               input logic next_v, input int inj, input logic [7:0] inj_d);
        logic [4:0] e;
        for (int i = 0; i < 10; i++) begin
            e = {1'b1, bits[9-i], 1'(i == 0), 1'(i == 9), 1'(i == 9)};
            chk($sformatf("%s bit%0d {valid,sout,start,last,ready}", nm, i),
                32'({bus.sout_valid, bus.sout, bus.frame_start, bus.frame_last, bus.din_ready}), 32'(e));
            if (i == 0) begin
                bus.din = next_d;
                bus.din_valid = next_v;
            end
            if (i == inj) begin
                bus.din = inj_d;
                bus.din_valid = 1'b1;
            end
            @(negedge clk);
        end
    endtask
    task automatic start_word(input string nm, input logic [7:0] w);
        bus.din = w;
        bus.din_valid = 1'b1;
        chk({nm, " ready in idle"}, 32'(bus.din_ready), 32'd1);
        @(negedge clk);
    endtask
    initial begin
        logic [9:0] fb;
        int len, seen, cyc, w;
        logic in_frame, chk_res;
        logic [1:0] exp_r;
        tbl[0] = '{8'h07, 10'b0000011101, 2'd1};
        tbl[1] = '{8'h80, 10'b1000000010, 2'd2};
        tbl[2] = '{8'hFF, 10'b1111111100, 2'd0};
        tbl[3] = '{8'hAA, 10'b1010101010, 2'd2};
        tbl[4] = '{8'h00, 10'b0000000000, 2'd0};
        tbl[5] = '{8'h03, 10'b0000001100, 2'd0};
        bus.din = '0;
        bus.din_valid = 1'b0;
        #1;
        chk("reset outputs", 32'({bus.sout, bus.sout_valid, bus.frame_start, bus.frame_last, bus.residue, bus.din_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(bus.din_ready), 32'd1);
        @(negedge clk);
        chk("idle sout_valid", 32'({bus.sout_valid, bus.sout}), 32'd0);
        for (int k = 0; k < 6; k++) begin
            start_word($sformatf("tbl%0d", k), tbl[k].d);
            frame_check($sformatf("tbl%0d", k), tbl[k].bits, 8'h00, 1'b0, -1, 8'h00);
            chk($sformatf("tbl%0d residue", k), 32'(bus.residue), 32'(tbl[k].res));
            chk($sformatf("tbl%0d idle after", k), 32'({bus.sout_valid, bus.din_ready}), 32'b01);
        end
        start_word("b2b", 8'h07);
        frame_check("b2b f1", tbl[0].bits, 8'h80, 1'b1, -1, 8'h00);
        chk("b2b residue f1", 32'(bus.residue), 32'd1);
        frame_check("b2b f2", tbl[1].bits, 8'h00, 1'b0, -1, 8'h00);
        chk("b2b residue f2", 32'(bus.residue), 32'd2);
        chk("b2b idle after", 32'(bus.sout_valid), 32'd0);
        start_word("mid", 8'h07);
        frame_check("mid f1", tbl[0].bits, 8'h00, 1'b0, 3, 8'h55);
        frame_check("mid 0x55", 10'b0101010101, 8'h00, 1'b0, -1, 8'h00);
        chk("mid residue", 32'(bus.residue), 32'd1);
        start_word("rst", 8'hAA);
        bus.din_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst pre data5", 32'({bus.sout_valid, bus.sout, bus.frame_start}), 32'b110);
        rst = 1'b1;
        #1;
        chk("rst mid-frame outputs", 32'({bus.sout_valid, bus.frame_start, bus.frame_last, bus.din_ready, bus.residue}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst release idle", 32'({bus.sout_valid, bus.din_ready}), 32'b01);
        @(negedge clk);
        start_word("post-rst", 8'h03);
        frame_check("post-rst", tbl[5].bits, 8'h00, 1'b0, -1, 8'h00);
        chk("post-rst residue", 32'(bus.residue), 32'd0);
        // Random run: driver and monitor share no state except the expected-word queue.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    int gap, wait_c;
                    gap = $urandom_range(0, 3);
                    if (gap > 1) begin
                        bus.din_valid = 1'b0;
                        repeat (gap - 1) @(negedge clk);
                    end
                    bus.din = 8'($urandom);
                    bus.din_valid = 1'b1;
                    wait_c = 0;
                    while (!bus.din_ready && wait_c < 50) begin
                        @(negedge clk);
                        wait_c++;
                    end
                    if (!bus.din_ready) begin
                        chk("rand ready timeout", 32'(bus.din_ready), 32'd1);
                        break;
                    end
                    exp_q.push_back(bus.din);
                    @(negedge clk);
                    bus.din_valid = 1'b0;
                end
                bus.din_valid = 1'b0;
            end
            begin
                seen = 0;
                cyc = 0;
                len = 0;
                fb = '0;
                in_frame = 1'b0;
                chk_res = 1'b0;
                exp_r = '0;
                while ((seen < 1000 || chk_res) && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    if (chk_res) begin
                        chk("rand residue port", 32'(bus.residue), 32'(exp_r));
                        chk_res = 1'b0;
                    end
                    if (!bus.sout_valid && in_frame) begin
                        chk("rand gap inside frame", 32'(len), 32'd10);
                        in_frame = 1'b0;
                    end
                    if (bus.sout_valid) begin
                        if (bus.frame_start) begin
                            if (in_frame) chk("rand early frame_start", 32'(len), 32'd10);
                            in_frame = 1'b1;
                            len = 0;
                        end
                        fb = {fb[8:0], bus.sout};
                        len++;
                        if (bus.frame_last) begin
                            chk("rand frame length", 32'(len), 32'd10);
                            if (exp_q.size() == 0) begin
                                chk("rand unexpected frame", 32'(fb), 32'h3FF_FFFF);
                            end else begin
                                w = int'(exp_q.pop_front());
                                exp_r = 2'(w % 3);
                                chk("rand frame bits", 32'(fb), 32'({8'(w), exp_r}));
                                chk_res = 1'b1;
                            end
                            in_frame = 1'b0;
                            seen++;
                        end
                    end
                end
                if (seen < 1000) chk("rand frames seen", 32'(seen), 32'd1000);
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
